// File: rtl/clock_divider.sv
// Integer clock divider: clk_out is low for floor(DIV/2) cycles and high for the rest.
// The output comes straight from a flop, and all outputs are phase-aligned to reset release.
module clock_divider #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic clk_out
);

  localparam int W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST  = W'(DIV - 1);
  localparam logic [W-1:0] LOW_C = W'(DIV / 2);

  generate
    if (DIV < 2 || DIV > 65536) begin : g_bad_div
      $error("clock_divider: DIV=%0d outside legal range 2..65536", DIV);
    end
  endgenerate

  logic [W-1:0] cnt_q, cnt_d;
  logic         clk_out_q, clk_out_d;

  // clk_out follows the next count value, so a rise lands on the edge where the count reaches LOW.
  always_comb begin
    cnt_d     = (cnt_q == LAST) ? '0 : cnt_q + W'(1);
    clk_out_d = (cnt_d >= LOW_C);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q     <= '0;
      clk_out_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      clk_out_q <= clk_out_d;
    end
  end

  assign clk_out = clk_out_q;

endmodule

// File: tb/tb_clock_divider.sv
// Bench for clock_divider: DIV=8, 16, 5 and 2 share one clock and reset.
// Expected levels per edge are queued by the driver and checked by a monitor on the falling edge.
module tb_clock_divider;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic o8, o16, o5, o2;

  always #5 clk = ~clk;

  clock_divider #(.DIV(8))  u_div8  (.clk(clk), .reset(reset), .clk_out(o8));
  clock_divider #(.DIV(16)) u_div16 (.clk(clk), .reset(reset), .clk_out(o16));
  clock_divider #(.DIV(5))  u_div5  (.clk(clk), .reset(reset), .clk_out(o5));
  clock_divider #(.DIV(2))  u_div2  (.clk(clk), .reset(reset), .clk_out(o2));

  // Entry bits: {div8, div16, div5, div2}
  logic [3:0] exp_q[$];
  int         tag_q[$];
  int         n_cmp = 0;
  int         n_err = 0;

  // One period of each output, indexed by edge number after release modulo DIV.
  string p8  = "00001111";
  string p16 = "0000000011111111";
  string p5  = "00111";
  string p2  = "01";

  function automatic logic [3:0] expected_at(input int n);
    logic [3:0] v;
    v[3] = (p8[n % 8]   == "1");
    v[2] = (p16[n % 16] == "1");
    v[1] = (p5[n % 5]   == "1");
    v[0] = (p2[n % 2]   == "1");
    return v;
  endfunction

  // n is the edge number after release; n=0 means this edge samples reset low.
  task automatic step(input logic r, input int n, input logic glitch);
    reset = r;
    if (glitch) begin
      #2 reset = ~r;
      #2 reset = r;
    end
    @(posedge clk);
    #1;
    exp_q.push_back(r ? expected_at(n) : 4'b0000);
    tag_q.push_back(n);
  endtask

  task automatic check_bit(input string name, input int n, input logic got, input logic want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s edge %0d: got %b want %b", name, n, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [3:0] e;
      int         n;
      e = exp_q.pop_front();
      n = tag_q.pop_front();
      check_bit("div8",  n, o8,  e[3]);
      check_bit("div16", n, o16, e[2]);
      check_bit("div5",  n, o5,  e[1]);
      check_bit("div2",  n, o2,  e[0]);
    end
  end

  initial begin
    // Reset low for two edges, then 50 edges of free running.
    step(1'b0, 0, 1'b0);
    step(1'b0, 0, 1'b0);
    for (int i = 1; i <= 50; i++) step(1'b1, i, 1'b0);

    // Fresh start, then reset pulsed low for one edge while div8 is high (edge 6).
    step(1'b0, 0, 1'b0);
    for (int i = 1; i <= 6; i++) step(1'b1, i, 1'b0);
    step(1'b0, 0, 1'b0);
    for (int i = 1; i <= 14; i++) step(1'b1, i, 1'b0);

    // Reset glitches between edges must be ignored.
    for (int i = 15; i <= 26; i++) step(1'b1, i, (i % 3) == 0);

    // Reset held low with high glitches between edges must keep everything at 0.
    for (int i = 0; i < 3; i++) step(1'b0, 0, 1'b1);
    for (int i = 1; i <= 5; i++) step(1'b1, i, 1'b0);

    @(posedge clk);
    @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d entries left want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
